// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the memory stage: funct3 load/store sizes,
// writeback source selects and the memory handshake FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and misalignment detection.
module load_store_align #(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);
  import riscv_pkg::*;

  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic       illegal;
  logic [1:0] lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: is_byte = 1'b1;
      F3_H, F3_HU: is_half = 1'b1;
      F3_W:        is_word = 1'b1;
      default: begin
        is_word = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

  // Low address bits below the access size are dropped, so with the check
  // disabled a misaligned access silently rounds down to its natural boundary.
  always_comb begin
    lane = 2'b00;
    if (is_byte)      lane = addr[1:0];
    else if (is_half) lane = {addr[1], 1'b0};
  end

  always_comb begin
    misalign = 1'b0;
    if (MISALIGN_CHK) begin
      misalign = illegal ||
                 (is_half && addr[0]) ||
                 (is_word && (addr[1:0] != 2'b00));
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      if (is_byte) begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end else if (is_half) begin
        be    = 4'b0011 << lane;
        wdata = {2{store_data[15:0]}};
      end
    end
  end

  always_comb begin
    byte_sel = rdata_raw[7:0];
    unique case (addr[1:0])
      2'b00: byte_sel = rdata_raw[7:0];
      2'b01: byte_sel = rdata_raw[15:8];
      2'b10: byte_sel = rdata_raw[23:16];
      2'b11: byte_sel = rdata_raw[31:24];
      default: byte_sel = rdata_raw[7:0];
    endcase
    half_sel = addr[1] ? rdata_raw[31:16] : rdata_raw[15:0];

    // funct3[2] distinguishes the unsigned load variants.
    if (is_byte) begin
      rdata_ext = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      rdata_ext = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      rdata_ext = rdata_raw;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: data-memory req/ack handshake with stall generation and
// the M/W pipeline register feeding the writeback mux.
module memory_stage #(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW
);
  import riscv_pkg::*;

  mem_state_t  state_q;
  mem_state_t  state_d;
  logic        mem_op;
  logic        misalign_raw;
  logic [31:0] rdata_ext;

  load_store_align #(
    .MISALIGN_CHK(MISALIGN_CHK)
  ) u_align (
    .is_store  (MemWriteM),
    .funct3    (Funct3M),
    .addr      (ALUResultM),
    .store_data(WriteDataM),
    .rdata_raw (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .rdata_ext (rdata_ext),
    .misalign  (misalign_raw)
  );

  assign mem_op    = ValidM && (MemWriteM || (ResultSrcM == RES_MEM));
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  // Gating with reset withdraws the request in the same cycle reset asserts.
  always_comb begin
    dmem_req  = 1'b0;
    MisalignM = 1'b0;
    if (reset) begin
      dmem_req  = (state_q == WAIT) || (mem_op && !misalign_raw);
      MisalignM = (state_q == IDLE) && mem_op && misalign_raw;
    end
    dmem_we = dmem_req && MemWriteM;
    StallM  = dmem_req && !dmem_ack;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dmem_req && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      PCPlus4W   <= 32'h0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
    end else begin
      if (!StallM && ValidM) begin
        RegWriteW  <= RegWriteM && !MisalignM;
        ResultSrcW <= ResultSrcM;
        RdW        <= RdM;
        PCPlus4W   <= PCPlus4M;
        ALUResultW <= ALUResultM;
      end else begin
        RegWriteW <= 1'b0;
      end
      if (dmem_req && dmem_ack && !MemWriteM) begin
        ReadDataW <= rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected W-stage contents are queued when an
// instruction is presented and compared one clock later.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        MisalignM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;

  memory_stage #(
    .MISALIGN_CHK(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ValidM    (ValidM),
    .RegWriteM (RegWriteM),
    .ResultSrcM(ResultSrcM),
    .MemWriteM (MemWriteM),
    .Funct3M   (Funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .RdM       (RdM),
    .PCPlus4M  (PCPlus4M),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_be   (dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .StallM    (StallM),
    .MisalignM (MisalignM),
    .RegWriteW (RegWriteW),
    .ResultSrcW(ResultSrcW),
    .RdW       (RdW),
    .PCPlus4W  (PCPlus4W),
    .ALUResultW(ALUResultW),
    .ReadDataW (ReadDataW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] rdata;
  } wexp_t;

  wexp_t model;
  wexp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic [1:0] rs,
                           input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] pc4);
    ValidM = v; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
    ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
  endtask

  // Expected W contents when the presented instruction is accepted.
  task automatic exp_accept(input logic rw, input logic upd_rdata, input logic [31:0] rdata);
    model.rw  = rw;
    model.rs  = ResultSrcM;
    model.rd  = RdM;
    model.pc4 = PCPlus4M;
    model.alu = ALUResultM;
    if (upd_rdata) model.rdata = rdata;
    exp_q.push_back(model);
  endtask

  task automatic exp_bubble();
    model.rw = 1'b0;
    exp_q.push_back(model);
  endtask

  task automatic step_check(input string tag);
    wexp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_RegWriteW"},  {31'd0, RegWriteW}, {31'd0, e.rw});
      chk({tag, "_ResultSrcW"}, {30'd0, ResultSrcW}, {30'd0, e.rs});
      chk({tag, "_RdW"},        {27'd0, RdW}, {27'd0, e.rd});
      chk({tag, "_PCPlus4W"},   PCPlus4W, e.pc4);
      chk({tag, "_ALUResultW"}, ALUResultW, e.alu);
      chk({tag, "_ReadDataW"},  ReadDataW, e.rdata);
    end
  endtask

  // Memory op already driven; stall for 'waits' cycles then acknowledge.
  task automatic run_mem(input string tag, input int waits, input logic is_load,
                         input logic [31:0] exp_rdata);
    dmem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      #2;
      chk({tag, "_stall"}, {31'd0, StallM}, 32'd1);
      chk({tag, "_req_wait"}, {31'd0, dmem_req}, 32'd1);
      exp_bubble();
      step_check({tag, "_bubble"});
    end
    dmem_ack = 1'b1;
    #2;
    chk({tag, "_stall_ack"}, {31'd0, StallM}, 32'd0);
    chk({tag, "_req_ack"}, {31'd0, dmem_req}, 32'd1);
    exp_accept(RegWriteM, is_load, exp_rdata);
    step_check(tag);
    dmem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    set_instr(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
    model = '0;
    #3;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_misalign", {31'd0, MisalignM}, 32'd0);
    chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
    chk("rst_readdata", ReadDataW, 32'h0);
    chk("rst_pc4", PCPlus4W, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // SW 0x100, zero wait
    set_instr(1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h8);
    #1;
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    run_mem("sw", 0, 1'b0, 32'h0);

    // SB 0x103
    set_instr(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'hC);
    #1;
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", dmem_addr, 32'h100);
    run_mem("sb", 0, 1'b0, 32'h0);

    // LB / LBU 0x102 with three wait cycles
    dmem_rdata = 32'h0080FF00;
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 32'h102, 32'h0, 5'd5, 32'h10);
    #1;
    chk("lb_be", {28'd0, dmem_be}, 32'hF);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    run_mem("lb", 3, 1'b1, 32'hFFFFFF80);
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b100, 32'h102, 32'h0, 5'd6, 32'h14);
    run_mem("lbu", 3, 1'b1, 32'h00000080);

    // Misaligned LH/LW, with a stray ack that must not update ReadDataW
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b001, 32'h101, 32'h0, 5'd7, 32'h18);
    dmem_ack = 1'b1;
    #2;
    chk("lh_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lh_mis_flag", {31'd0, MisalignM}, 32'd1);
    chk("lh_mis_stall", {31'd0, StallM}, 32'd0);
    exp_accept(1'b0, 1'b0, 32'h0);
    step_check("lh_mis");
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'h0, 5'd8, 32'h1C);
    #2;
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_flag", {31'd0, MisalignM}, 32'd1);
    exp_accept(1'b0, 1'b0, 32'h0);
    step_check("lw_mis");
    dmem_ack = 1'b0;

    // Reset while in WAIT
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9, 32'h20);
    #2;
    chk("wr_stall", {31'd0, StallM}, 32'd1);
    exp_bubble();
    step_check("wr_enter");
    #2;
    reset = 1'b0;
    #1;
    chk("wr_req", {31'd0, dmem_req}, 32'd0);
    chk("wr_stall_rst", {31'd0, StallM}, 32'd0);
    chk("wr_regwrite", {31'd0, RegWriteW}, 32'd0);
    chk("wr_readdata", ReadDataW, 32'h0);
    chk("wr_alu", ALUResultW, 32'h0);
    chk("wr_rd", {27'd0, RdW}, 32'd0);
    chk("wr_pc4", PCPlus4W, 32'h0);
    chk("wr_rsrc", {30'd0, ResultSrcW}, 32'd0);
    exp_q.delete();
    model = '0;
    ValidM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    dmem_ack = 1'b1;
    #2;
    chk("stray_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_stall", {31'd0, StallM}, 32'd0);
    exp_bubble();
    step_check("stray");
    dmem_ack = 1'b0;

    // ADD, LW (zero wait), JAL back to back
    set_instr(1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'h7, 32'h0, 5'd3, 32'h40);
    #2;
    chk("add_req", {31'd0, dmem_req}, 32'd0);
    exp_accept(1'b1, 1'b0, 32'h0);
    step_check("add");
    dmem_rdata = 32'h12345678;
    set_instr(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'h0, 5'd4, 32'h44);
    run_mem("lw", 0, 1'b1, 32'h12345678);
    set_instr(1'b1, 1'b1, 2'b10, 1'b0, 3'b000, 32'h50, 32'h0, 5'd1, 32'h48);
    #2;
    chk("jal_req", {31'd0, dmem_req}, 32'd0);
    exp_accept(1'b1, 1'b0, 32'h0);
    step_check("jal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
